bitty_mem_arbiter: RTL and testbench

- Shares one single-port synchronous memory between two requesters:
  - instruction-fetch port (if_*), read-only;
  - core data port (d_*), load/store.
- Sits between the fetch unit / bitty core and the memory macro.
- Replaces ad-hoc memory steering with a req/gnt/valid handshake.
- Policy: data priority, with a starvation bound for fetch.

---
 rtl/bitty_mem_pkg.sv | 32 +++
 rtl/bitty_mem_arbiter_if.sv | 55 +++++
 rtl/bitty_mem_arb_pick.sv | 109 ++++++++++
 rtl/bitty_mem_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_bitty_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bitty_mem_pkg.sv
// -----------------------------------------------------------------------------
// bitty_mem_pkg
// Shared types and constants for the bitty memory arbiter.
//   - state_t : arbiter FSM states (IDLE, ISSUE, WAIT)
//   - owner_t : which requester owns the current access (OWN_IF, OWN_D)
//   - BITTY_ADDR_W / BITTY_DATA_W : default memory geometry, also used by the
//     fetch unit and the bitty core
//   - BITTY_MAX_WAIT : default starvation bound for the fetch port
// -----------------------------------------------------------------------------
package bitty_mem_pkg;

    localparam int BITTY_ADDR_W   = 8;
    localparam int BITTY_DATA_W   = 16;
    localparam int BITTY_MAX_WAIT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // The requester that did not own the given access.
    function automatic owner_t other_owner(input owner_t own);
        return (own == OWN_IF) ? OWN_D : OWN_IF;
    endfunction

endpackage : bitty_mem_pkg

// File: rtl/bitty_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// bitty_mem_arbiter_if
// Bundles the fetch port, the data port and the memory-macro port of the
// bitty memory arbiter.
//   slave  modport : the arbiter's view (requests and mem_rdata in,
//                    grants, responses and memory drive out)
//   master modport : the environment's view (fetch unit, core, memory macro)
// Signals:
//   if_req/if_addr -> if_gnt/if_valid/if_rdata      fetch (read-only)
//   d_req/d_we/d_addr/d_wdata -> d_gnt/d_valid/d_rdata   data load/store
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata     memory macro
//   busy                                            arbiter not in IDLE
// -----------------------------------------------------------------------------
interface bitty_mem_arbiter_if
    import bitty_mem_pkg::*;
#(
    parameter int ADDR_W = BITTY_ADDR_W,
    parameter int DATA_W = BITTY_DATA_W
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface : bitty_mem_arbiter_if

// File: rtl/bitty_mem_arb_pick.sv
// -----------------------------------------------------------------------------
// bitty_mem_arb_pick
// Winner selection for the bitty memory arbiter.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   i_if_req    : fetch request pending
//   i_d_req     : data request pending
//   i_arb       : arbitration strobe (arbiter is in IDLE this cycle)
//   o_winner    : combinational winner for the current request pair
// Build option:
//   BITTY_MEM_ARB_RR_EN undefined : data priority; a fetch that has lost
//       MAX_WAIT arbitrations in a row wins the next one.
//   BITTY_MEM_ARB_RR_EN defined   : round-robin on contention, tracked by a
//       last-owner flop; MAX_WAIT is not used.
// -----------------------------------------------------------------------------
module bitty_mem_arb_pick
    import bitty_mem_pkg::*;
#(
    parameter int MAX_WAIT = BITTY_MAX_WAIT
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_if_req,
    input  logic   i_d_req,
    input  logic   i_arb,
    output owner_t o_winner
);

    owner_t w_winner;

`ifdef BITTY_MEM_ARB_RR_EN

    owner_t r_last;

    // Winner select: on contention the requester not granted last time wins.
    always_comb begin
        w_winner = OWN_IF;
        if (i_if_req && i_d_req) begin
            w_winner = other_owner(r_last);
        end else if (i_d_req) begin
            w_winner = OWN_D;
        end else begin
            w_winner = OWN_IF;
        end
    end

    // Last-owner flop: updated on every grant (any request seen in IDLE).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= OWN_IF;
        end else if (i_arb && (i_if_req || i_d_req)) begin
            r_last <= w_winner;
        end else begin
            r_last <= r_last;
        end
    end

`else

    localparam int                CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  MAX_C = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0]  ONE_C = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Winner select: data first unless the fetch has hit its starvation bound.
    always_comb begin
        w_winner = OWN_IF;
        if (i_if_req && i_d_req) begin
            w_winner = (r_cnt >= MAX_C) ? OWN_IF : OWN_D;
        end else if (i_d_req) begin
            w_winner = OWN_D;
        end else begin
            w_winner = OWN_IF;
        end
    end

    // Starvation count: only moves while a fetch is pending at arbitration;
    // clears when the fetch wins, saturates at MAX_WAIT.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_arb && i_if_req) begin
            if (w_winner == OWN_IF) begin
                w_cnt_nxt = {CNT_W{1'b0}};
            end else if (r_cnt < MAX_C) begin
                w_cnt_nxt = r_cnt + ONE_C;
            end else begin
                w_cnt_nxt = r_cnt;
            end
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

`endif

    assign o_winner = w_winner;

endmodule : bitty_mem_arb_pick

// File: rtl/bitty_mem_arbiter.sv
// -----------------------------------------------------------------------------
// bitty_mem_arbiter
// Shares one single-port synchronous memory between the instruction-fetch
// port (read-only) and the core data port (load/store) using a
// req/gnt/valid handshake.  One access every three cycles:
//   edge N   : IDLE samples requests, winner chosen
//   cycle N+1: ISSUE - mem_en/mem_we/mem_addr/mem_wdata driven, gnt pulse
//   cycle N+2: WAIT  - memory returns mem_rdata, captured at the next edge
//   cycle N+3: IDLE  - valid pulse, next requests sampled
// Ports:
//   clk, reset : clock, asynchronous active-high reset (all outputs to 0)
//   bus        : bitty_mem_arbiter_if.slave (fetch, data and memory ports)
// Parameters: ADDR_W, DATA_W, MAX_WAIT (starvation bound for fetch).
// Build option: BITTY_MEM_ARB_RR_EN selects round-robin arbitration in
// bitty_mem_arb_pick instead of data priority with a starvation bound.
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module bitty_mem_arbiter
    import bitty_mem_pkg::*;
#(
    parameter int ADDR_W   = BITTY_ADDR_W,
    parameter int DATA_W   = BITTY_DATA_W,
    parameter int MAX_WAIT = BITTY_MAX_WAIT
) (
    input  logic               clk,
    input  logic               reset,
    bitty_mem_arbiter_if.slave bus
);

    state_t r_state;
    state_t w_state_nxt;

    owner_t r_owner;
    owner_t w_owner_nxt;
    logic   r_store;
    logic   w_store_nxt;

    logic              r_if_gnt,    w_if_gnt_nxt;
    logic              r_if_valid,  w_if_valid_nxt;
    logic [DATA_W-1:0] r_if_rdata,  w_if_rdata_nxt;
    logic              r_d_gnt,     w_d_gnt_nxt;
    logic              r_d_valid,   w_d_valid_nxt;
    logic [DATA_W-1:0] r_d_rdata,   w_d_rdata_nxt;
    logic              r_mem_en,    w_mem_en_nxt;
    logic              r_mem_we,    w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic              r_busy,      w_busy_nxt;

    logic   w_any_req;
    logic   w_arb;
    owner_t w_winner;

    assign w_any_req = bus.if_req | bus.d_req;
    assign w_arb     = (r_state == IDLE);

    bitty_mem_arb_pick #(
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .clk      (clk),
        .reset    (reset),
        .i_if_req (bus.if_req),
        .i_d_req  (bus.d_req),
        .i_arb    (w_arb),
        .o_winner (w_winner)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: IDLE waits for a request, then a fixed ISSUE/WAIT pair.
    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ISSUE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: next values of the output registers.  Pulses default low,
    // memory address/data and read-data registers default to holding.
    always_comb begin
        w_if_gnt_nxt    = 1'b0;
        w_d_gnt_nxt     = 1'b0;
        w_if_valid_nxt  = 1'b0;
        w_d_valid_nxt   = 1'b0;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_d_rdata_nxt   = r_d_rdata;
        w_owner_nxt     = r_owner;
        w_store_nxt     = r_store;
        w_busy_nxt      = (w_state_nxt != IDLE);
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_owner_nxt  = w_winner;
                    w_mem_en_nxt = 1'b1;
                    if (w_winner == OWN_D) begin
                        w_d_gnt_nxt    = 1'b1;
                        w_mem_addr_nxt = bus.d_addr;
                        w_mem_we_nxt   = bus.d_we;
                        w_store_nxt    = bus.d_we;
                        if (bus.d_we) begin
                            w_mem_wdata_nxt = bus.d_wdata;
                        end else begin
                            w_mem_wdata_nxt = r_mem_wdata;
                        end
                    end else begin
                        // Fetch is read-only: never a write, wdata untouched.
                        w_if_gnt_nxt   = 1'b1;
                        w_mem_addr_nxt = bus.if_addr;
                        w_mem_we_nxt   = 1'b0;
                        w_store_nxt    = 1'b0;
                    end
                end else begin
                    w_owner_nxt = r_owner;
                end
            end
            ISSUE: begin
                w_mem_en_nxt = 1'b0;
            end
            WAIT: begin
                // mem_rdata is valid now (one cycle after mem_en).
                if (r_owner == OWN_IF) begin
                    w_if_valid_nxt = 1'b1;
                    w_if_rdata_nxt = bus.mem_rdata;
                end else begin
                    w_d_valid_nxt = 1'b1;
                    if (!r_store) begin
                        w_d_rdata_nxt = bus.mem_rdata;
                    end else begin
                        w_d_rdata_nxt = r_d_rdata;
                    end
                end
            end
            default: begin
                w_mem_en_nxt = 1'b0;
            end
        endcase
    end

    // Output and access-context registers; reset clears every output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if_gnt    <= 1'b0;
            r_if_valid  <= 1'b0;
            r_if_rdata  <= {DATA_W{1'b0}};
            r_d_gnt     <= 1'b0;
            r_d_valid   <= 1'b0;
            r_d_rdata   <= {DATA_W{1'b0}};
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {DATA_W{1'b0}};
            r_busy      <= 1'b0;
            r_owner     <= OWN_IF;
            r_store     <= 1'b0;
        end else begin
            r_if_gnt    <= w_if_gnt_nxt;
            r_if_valid  <= w_if_valid_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_d_gnt     <= w_d_gnt_nxt;
            r_d_valid   <= w_d_valid_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_busy      <= w_busy_nxt;
            r_owner     <= w_owner_nxt;
            r_store     <= w_store_nxt;
        end
    end

    assign bus.if_gnt    = r_if_gnt;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_gnt     = r_d_gnt;
    assign bus.d_valid   = r_d_valid;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = r_busy;

endmodule : bitty_mem_arbiter

// File: tb/tb_bitty_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bitty_mem_arbiter
// Self-checking bench for bitty_mem_arbiter.  A transaction-level model
// decides each arbitration from the requests seen at the clock edge and
// predicts grant, memory drive, busy window and response for the access;
// a compare process checks every output on every falling edge.  Directed
// scenarios add literal expectations; a random phase follows.
// Honours BITTY_MEM_ARB_RR_EN for the arbitration rule.
// -----------------------------------------------------------------------------
module tb_bitty_mem_arbiter;
    import bitty_mem_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int MW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bitty_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bitty_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] initv(input int i);
        logic [7:0] b;
        b = 8'(i);
        return (i == 16) ? 16'hBEEF : {b ^ 8'hA5, b};
    endfunction

    // Memory macro: synchronous single port, read data the cycle after mem_en.
    logic [DW-1:0] mem [256];
    bit            mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] = initv(i);
            mem_init = 1'b1;
        end
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    // ---------------- behavioural model ----------------
    logic [DW-1:0] ref_mem [256];
    bit            ref_init = 1'b0;
    int            cyc = 0;        // edges seen; outputs after edge k are "cycle k"
    int            next_arb = 0;   // first edge at which a new arbitration may happen
    bit            p_act = 1'b0;   // an access has been started
    int            p_e = 0;        // edge at which it was granted
    bit            p_d = 1'b0;     // owner is data
    bit            p_we = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_wdata = '0;
    logic [DW-1:0] p_data = '0;
    logic [DW-1:0] e_if_rd = '0, e_d_rd = '0;
    logic [AW-1:0] e_addr = '0;
    int            cnt = 0;
    bit            last_d = 1'b0;
    bit            m_win_d;

    always @(posedge clk) begin
        if (!ref_init) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = initv(i);
            ref_init = 1'b1;
        end
        cyc++;
        if (reset) begin
            p_act = 1'b0; next_arb = 0; cnt = 0; last_d = 1'b0;
            e_if_rd = '0; e_d_rd = '0; e_addr = '0;
        end else begin
            if (p_act && cyc == p_e + 2) begin
                if (!p_d)       e_if_rd = p_data;
                else if (!p_we) e_d_rd  = p_data;
            end
            if (cyc >= next_arb && (bus.if_req || bus.d_req)) begin
`ifdef BITTY_MEM_ARB_RR_EN
                if (bus.if_req && bus.d_req) m_win_d = !last_d;
                else                         m_win_d = bus.d_req;
                last_d = m_win_d;
`else
                if (bus.if_req && bus.d_req) begin
                    if (cnt < MW) begin m_win_d = 1'b1; cnt++; end
                    else          begin m_win_d = 1'b0; cnt = 0; end
                end else if (bus.d_req) begin
                    m_win_d = 1'b1;
                end else begin
                    m_win_d = 1'b0; cnt = 0;
                end
`endif
                p_act   = 1'b1;
                p_e     = cyc;
                p_d     = m_win_d;
                p_we    = m_win_d && bus.d_we;
                p_addr  = m_win_d ? bus.d_addr : bus.if_addr;
                p_wdata = bus.d_wdata;
                p_data  = ref_mem[p_addr];
                if (p_we) ref_mem[p_addr] = p_wdata;
                e_addr   = p_addr;
                next_arb = cyc + 3;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        bit x_en, x_act1;
        x_en   = !reset && p_act && (cyc == p_e);
        x_act1 = !reset && p_act && (cyc == p_e + 1);
        chk("if_gnt",   32'(bus.if_gnt),   32'(x_en && !p_d));
        chk("d_gnt",    32'(bus.d_gnt),    32'(x_en && p_d));
        chk("mem_en",   32'(bus.mem_en),   32'(x_en));
        chk("mem_we",   32'(bus.mem_we),   32'(x_en && p_we));
        chk("busy",     32'(bus.busy),     32'(x_en || x_act1));
        chk("if_valid", 32'(bus.if_valid), 32'(!reset && p_act && cyc == p_e + 2 && !p_d));
        chk("d_valid",  32'(bus.d_valid),  32'(!reset && p_act && cyc == p_e + 2 && p_d));
        chk("mem_addr", 32'(bus.mem_addr), reset ? 32'd0 : 32'(e_addr));
        chk("if_rdata", 32'(bus.if_rdata), reset ? 32'd0 : 32'(e_if_rd));
        chk("d_rdata",  32'(bus.d_rdata),  reset ? 32'd0 : 32'(e_d_rd));
        if (x_en && p_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(p_wdata));
    end

    // ---------------- stimulus ----------------
    int gq[$];

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.if_gnt) gq.push_back(0);
        if (bus.d_gnt)  gq.push_back(1);
    endtask

    task automatic drive_if(input int pct);
        if (bus.if_req && bus.if_gnt) bus.if_req = 1'b0;
        else if (!bus.if_req && $urandom_range(0, 99) < pct) begin
            bus.if_req  = 1'b1;
            bus.if_addr = AW'($urandom);
        end
    endtask

    task automatic drive_d(input int pct);
        if (bus.d_req && bus.d_gnt) bus.d_req = 1'b0;
        else if (!bus.d_req && $urandom_range(0, 99) < pct) begin
            bus.d_req   = 1'b1;
            bus.d_we    = 1'($urandom);
            bus.d_addr  = AW'($urandom_range(0, 31));
            bus.d_wdata = DW'($urandom);
        end
    endtask

    int exp_seq [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef BITTY_MEM_ARB_RR_EN
        exp_seq = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
`else
        exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`endif
        reset = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (3) step();
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_mem_en", 32'(bus.mem_en), 32'd0);
        reset = 1'b0;

        // Idle: ten cycles without requests.
        gq.delete();
        repeat (10) step();
        chk("idle_no_gnt", 32'(gq.size()), 32'd0);

        // Single fetch of 0x10.
        bus.if_addr = 8'h10; bus.if_req = 1'b1;
        step();
        chk("fetch_gnt", 32'(bus.if_gnt), 32'd1);
        chk("fetch_mem_addr", 32'(bus.mem_addr), 32'h10);
        chk("fetch_mem_we", 32'(bus.mem_we), 32'd0);
        bus.if_req = 1'b0;
        step();
        chk("fetch_busy_wait", 32'(bus.busy), 32'd1);
        step();
        chk("fetch_valid", 32'(bus.if_valid), 32'd1);
        chk("fetch_rdata", 32'(bus.if_rdata), 32'hBEEF);

        // Store 0x1234 to 0x20, then load it back.
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h20; bus.d_wdata = 16'h1234;
        step();
        chk("store_gnt", 32'(bus.d_gnt), 32'd1);
        chk("store_mem_we", 32'(bus.mem_we), 32'd1);
        chk("store_wdata", 32'(bus.mem_wdata), 32'h1234);
        bus.d_req = 1'b0;
        step(); step();
        chk("store_valid", 32'(bus.d_valid), 32'd1);
        bus.d_req = 1'b1; bus.d_we = 1'b0;
        step();
        chk("load_gnt", 32'(bus.d_gnt), 32'd1);
        bus.d_req = 1'b0;
        step(); step();
        chk("load_valid", 32'(bus.d_valid), 32'd1);
        chk("load_rdata", 32'(bus.d_rdata), 32'h1234);

        // Reset during the WAIT cycle of a fetch.
        bus.if_addr = 8'h33; bus.if_req = 1'b1;
        step();
        bus.if_req = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_if_rdata", 32'(bus.if_rdata), 32'd0);
        chk("rst_d_rdata", 32'(bus.d_rdata), 32'd0);
        step();
        chk("rst_no_valid", 32'(bus.if_valid), 32'd0);
        reset = 1'b0;
        bus.if_addr = 8'h10; bus.if_req = 1'b1;
        step();
        chk("post_rst_gnt", 32'(bus.if_gnt), 32'd1);
        bus.if_req = 1'b0;
        step(); step();
        chk("post_rst_rdata", 32'(bus.if_rdata), 32'hBEEF);

        // Contention from a clean reset: both requesters always pending.
        reset = 1'b1;
        step();
        reset = 1'b0;
        gq.delete();
        for (int i = 0; i < 80 && gq.size() < 10; i++) begin
            drive_if(100);
            drive_d(100);
            step();
        end
        chk("contention_grants", 32'(gq.size() >= 10), 32'd1);
        for (int i = 0; i < 10 && i < gq.size(); i++)
            chk($sformatf("contention_order[%0d]", i), 32'(gq[i]), 32'(exp_seq[i]));

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            drive_if(30);
            drive_d(40);
            step();
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        repeat (6) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_bitty_mem_arbiter
